calc_token_sequencer: RTL and testbench



---
 rtl/calc_token_sequencer_if.sv | 37 +++
 rtl/calc_token_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_calc_token_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_token_sequencer_if.sv
// Purpose: bundles the token, calculator-pair and result channels that connect
//          the keypad decoder, the token sequencer and the stack calculator.
// Signals:
//   token_valid/token/token_ready           decoder -> sequencer token handshake
//   calc_valid/calc_operand/calc_op/calc_ready  sequencer -> calculator pair handshake
//   result_valid/result/result_error        calculator -> sequencer result strobe
// Modports: slave = sequencer view, master = environment (decoder + calculator) view.
interface calc_token_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              token_valid;
    logic [3:0]        token;
    logic              token_ready;
    logic              calc_valid;
    logic [DATA_W-1:0] calc_operand;
    logic [3:0]        calc_op;
    logic              calc_ready;
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic              result_error;

    modport slave (
        input  token_valid, token,
        output token_ready,
        output calc_valid, calc_operand, calc_op,
        input  calc_ready,
        input  result_valid, result, result_error
    );

    modport master (
        output token_valid, token,
        input  token_ready,
        input  calc_valid, calc_operand, calc_op,
        output calc_ready,
        output result_valid, result, result_error
    );
endinterface

// File: rtl/calc_token_sequencer.sv
// Purpose: sequences keypad tokens into operand/operator pairs for the stack
//          calculator, accumulating decimal digits, checking syntax, timing out
//          on a missing result and supporting 'C' clear and answer chaining.
// Ports:
//   i_clock         system clock, rising edge
//   i_reset         synchronous active-high reset
//   bus             token / calc pair / result channels (slave modport)
//   o_calc_clear    one-cycle pulse telling the calculator to drop its stack
//   o_answer_valid  o_answer holds a final result
//   o_answer        final result
//   o_err_code      0 none, 1 overflow, 2 syntax, 3 calc error, 4 timeout
//   o_state         0 IDLE, 1 SEND, 2 WAIT_RESULT, 3 DONE, 4 ERROR
module calc_token_sequencer #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    calc_token_sequencer_if.slave bus,
    output logic                 o_calc_clear,
    output logic                 o_answer_valid,
    output logic [DATA_W-1:0]    o_answer,
    output logic [2:0]           o_err_code,
    output logic [2:0]           o_state
);

    localparam int unsigned TIMER_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned ACC_EXT_W = DATA_W + 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_OVERFLOW = 3'd1;
    localparam logic [2:0] E_SYNTAX   = 3'd2;
    localparam logic [2:0] E_CALC     = 3'd3;
    localparam logic [2:0] E_TIMEOUT  = 3'd4;

    localparam logic [3:0] TOK_EQ    = 4'd14;
    localparam logic [3:0] TOK_CLEAR = 4'd15;

    // Registered state and outputs
    logic [2:0]         r_state;
    logic [DATA_W-1:0]  r_acc;
    logic               r_digit_seen;
    logic [TIMER_W-1:0] r_timer;
    logic               r_token_ready;
    logic               r_calc_valid;
    logic [DATA_W-1:0]  r_calc_operand;
    logic [3:0]         r_calc_op;
    logic               r_calc_clear;
    logic               r_answer_valid;
    logic [DATA_W-1:0]  r_answer;
    logic [2:0]         r_err_code;

    // Next-state values
    logic [2:0]         w_state_nx;
    logic [DATA_W-1:0]  w_acc_nx;
    logic               w_digit_seen_nx;
    logic [TIMER_W-1:0] w_timer_nx;
    logic [DATA_W-1:0]  w_calc_operand_nx;
    logic [3:0]         w_calc_op_nx;
    logic               w_calc_clear_nx;
    logic               w_answer_valid_nx;
    logic [DATA_W-1:0]  w_answer_nx;
    logic [2:0]         w_err_code_nx;

    // Token decode
    logic                 w_tok_fire;
    logic                 w_is_digit;
    logic                 w_is_op;
    logic                 w_is_chain_op;
    logic                 w_is_clear;
    logic [ACC_EXT_W-1:0] w_acc_ext;
    logic                 w_acc_ovf;

    assign w_tok_fire    = bus.token_valid & r_token_ready;
    assign w_is_digit    = (bus.token <= 4'd9);
    assign w_is_op       = (bus.token >= 4'd10) && (bus.token <= TOK_EQ);
    assign w_is_chain_op = (bus.token >= 4'd10) && (bus.token <= 4'd13);
    assign w_is_clear    = (bus.token == TOK_CLEAR);

    // acc*10+d evaluated 4 bits wider so any carry past DATA_W is visible
    assign w_acc_ext = (ACC_EXT_W'(r_acc) * ACC_EXT_W'(10)) + ACC_EXT_W'(bus.token);
    assign w_acc_ovf = |w_acc_ext[ACC_EXT_W-1:DATA_W];

    // Next-state and datapath decisions
    always_comb begin
        w_state_nx        = r_state;
        w_acc_nx          = r_acc;
        w_digit_seen_nx   = r_digit_seen;
        w_timer_nx        = r_timer;
        w_calc_operand_nx = r_calc_operand;
        w_calc_op_nx      = r_calc_op;
        w_calc_clear_nx   = 1'b0;
        w_answer_valid_nx = r_answer_valid;
        w_answer_nx       = r_answer;
        w_err_code_nx     = r_err_code;

        case (r_state)
            S_IDLE: begin
                if (w_tok_fire) begin
                    if (w_is_digit) begin
                        if (w_acc_ovf) begin
                            w_state_nx    = S_ERROR;
                            w_err_code_nx = E_OVERFLOW;
                        end else begin
                            w_acc_nx        = w_acc_ext[DATA_W-1:0];
                            w_digit_seen_nx = 1'b1;
                        end
                    end else if (w_is_op) begin
                        if (r_digit_seen) begin
                            w_state_nx        = S_SEND;
                            w_calc_operand_nx = r_acc;
                            w_calc_op_nx      = bus.token;
                        end else begin
                            w_state_nx    = S_ERROR;
                            w_err_code_nx = E_SYNTAX;
                        end
                    end
                end
            end
            S_SEND: begin
                if (bus.calc_ready) begin
                    if (r_calc_op == TOK_EQ) begin
                        w_state_nx = S_WAIT;
                        w_timer_nx = '0;
                    end else begin
                        w_state_nx      = S_IDLE;
                        w_acc_nx        = '0;
                        w_digit_seen_nx = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                // A result arriving in the final allowed cycle beats the timeout
                if (bus.result_valid) begin
                    if (bus.result_error) begin
                        w_state_nx    = S_ERROR;
                        w_err_code_nx = E_CALC;
                    end else begin
                        w_state_nx        = S_DONE;
                        w_answer_nx       = bus.result;
                        w_answer_valid_nx = 1'b1;
                    end
                end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nx    = S_ERROR;
                    w_err_code_nx = E_TIMEOUT;
                end else begin
                    w_timer_nx = r_timer + TIMER_W'(1);
                end
            end
            S_DONE: begin
                if (w_tok_fire) begin
                    if (w_is_digit) begin
                        w_state_nx        = S_IDLE;
                        w_acc_nx          = DATA_W'(bus.token);
                        w_digit_seen_nx   = 1'b1;
                        w_answer_valid_nx = 1'b0;
                    end else if (w_is_chain_op) begin
                        // Previous answer becomes the left operand
                        w_state_nx        = S_SEND;
                        w_calc_operand_nx = r_answer;
                        w_calc_op_nx      = bus.token;
                        w_answer_valid_nx = 1'b0;
                    end
                end
            end
            default: begin
                // ERROR: everything but 'C' is swallowed
            end
        endcase

        if (w_tok_fire && w_is_clear) begin
            w_state_nx        = S_IDLE;
            w_acc_nx          = '0;
            w_digit_seen_nx   = 1'b0;
            w_answer_valid_nx = 1'b0;
            w_err_code_nx     = E_NONE;
            w_calc_clear_nx   = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_digit_seen   <= 1'b0;
            r_timer        <= '0;
            r_token_ready  <= 1'b1;
            r_calc_valid   <= 1'b0;
            r_calc_operand <= '0;
            r_calc_op      <= '0;
            r_calc_clear   <= 1'b0;
            r_answer_valid <= 1'b0;
            r_answer       <= '0;
            r_err_code     <= E_NONE;
        end else begin
            r_state        <= w_state_nx;
            r_acc          <= w_acc_nx;
            r_digit_seen   <= w_digit_seen_nx;
            r_timer        <= w_timer_nx;
            r_token_ready  <= (w_state_nx == S_IDLE) || (w_state_nx == S_DONE) ||
                              (w_state_nx == S_ERROR);
            r_calc_valid   <= (w_state_nx == S_SEND);
            r_calc_operand <= w_calc_operand_nx;
            r_calc_op      <= w_calc_op_nx;
            r_calc_clear   <= w_calc_clear_nx;
            r_answer_valid <= w_answer_valid_nx;
            r_answer       <= w_answer_nx;
            r_err_code     <= w_err_code_nx;
        end
    end

    assign bus.token_ready  = r_token_ready;
    assign bus.calc_valid   = r_calc_valid;
    assign bus.calc_operand = r_calc_operand;
    assign bus.calc_op      = r_calc_op;
    assign o_calc_clear     = r_calc_clear;
    assign o_answer_valid   = r_answer_valid;
    assign o_answer         = r_answer;
    assign o_err_code       = r_err_code;
    assign o_state          = r_state;

endmodule

// File: tb/tb_calc_token_sequencer.sv
// Purpose: directed self-checking bench for calc_token_sequencer (DATA_W=8,
//          TIMEOUT_CYCLES=8); the bench plays both decoder and calculator.
module tb_calc_token_sequencer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic              calc_clear;
    logic              answer_valid;
    logic [DATA_W-1:0] answer;
    logic [2:0]        err_code;
    logic [2:0]        state;

    int n_cmp;
    int n_fail;

    calc_token_sequencer_if #(.DATA_W(DATA_W)) bus_if ();

    calc_token_sequencer #(
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .bus           (bus_if),
        .o_calc_clear  (calc_clear),
        .o_answer_valid(answer_valid),
        .o_answer      (answer),
        .o_err_code    (err_code),
        .o_state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tok(input logic [3:0] t);
        bus_if.token_valid = 1'b1;
        bus_if.token       = t;
        step();
        bus_if.token_valid = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus_if.token_valid  = 1'b0;
        bus_if.token        = 4'd0;
        bus_if.calc_ready   = 1'b0;
        bus_if.result_valid = 1'b0;
        bus_if.result       = '0;
        bus_if.result_error = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_state", 32'(state), 0);
        chk("rst_token_ready", 32'(bus_if.token_ready), 1);
        chk("rst_calc_valid", 32'(bus_if.calc_valid), 0);
        chk("rst_operand", 32'(bus_if.calc_operand), 0);
        chk("rst_op", 32'(bus_if.calc_op), 0);
        chk("rst_clear", 32'(calc_clear), 0);
        chk("rst_ans_valid", 32'(answer_valid), 0);
        chk("rst_answer", 32'(answer), 0);
        chk("rst_err", 32'(err_code), 0);

        // 12 + 3 = 15
        bus_if.calc_ready = 1'b1;
        tok(4'd1);
        tok(4'd2);
        tok(4'd10);
        chk("p1_state", 32'(state), 1);
        chk("p1_valid", 32'(bus_if.calc_valid), 1);
        chk("p1_operand", 32'(bus_if.calc_operand), 12);
        chk("p1_op", 32'(bus_if.calc_op), 10);
        step();
        chk("p1_after_state", 32'(state), 0);
        chk("p1_after_valid", 32'(bus_if.calc_valid), 0);
        chk("p1_after_ready", 32'(bus_if.token_ready), 1);
        tok(4'd3);
        tok(4'd14);
        chk("p2_operand", 32'(bus_if.calc_operand), 3);
        chk("p2_op", 32'(bus_if.calc_op), 14);
        chk("p2_token_ready", 32'(bus_if.token_ready), 0);
        step();
        chk("wait_state", 32'(state), 2);
        step();
        bus_if.result_valid = 1'b1;
        bus_if.result       = 8'd15;
        step();
        bus_if.result_valid = 1'b0;
        chk("ans15_state", 32'(state), 3);
        chk("ans15_valid", 32'(answer_valid), 1);
        chk("ans15_value", 32'(answer), 15);

        // Chaining: 15 * 2 = 30
        tok(4'd12);
        chk("chain_state", 32'(state), 1);
        chk("chain_operand", 32'(bus_if.calc_operand), 15);
        chk("chain_op", 32'(bus_if.calc_op), 12);
        chk("chain_ans_valid", 32'(answer_valid), 0);
        step();
        tok(4'd2);
        tok(4'd14);
        chk("chain_p2_operand", 32'(bus_if.calc_operand), 2);
        chk("chain_p2_op", 32'(bus_if.calc_op), 14);
        step();
        bus_if.result_valid = 1'b1;
        bus_if.result       = 8'd30;
        step();
        bus_if.result_valid = 1'b0;
        chk("ans30_state", 32'(state), 3);
        chk("ans30_value", 32'(answer), 30);

        // '=' in DONE is ignored, a digit restarts entry
        tok(4'd14);
        chk("done_eq_state", 32'(state), 3);
        tok(4'd7);
        chk("done_digit_state", 32'(state), 0);
        chk("done_digit_ansv", 32'(answer_valid), 0);
        tok(4'd15);
        chk("clr_pulse", 32'(calc_clear), 1);
        step();
        chk("clr_pulse_end", 32'(calc_clear), 0);

        // Overflow: 256 does not fit in 8 bits
        tok(4'd2);
        tok(4'd5);
        chk("ovf_pre_state", 32'(state), 0);
        tok(4'd6);
        chk("ovf_state", 32'(state), 4);
        chk("ovf_err", 32'(err_code), 1);
        tok(4'd3);
        chk("err_ignore_state", 32'(state), 4);
        chk("err_ignore_code", 32'(err_code), 1);
        tok(4'd15);
        chk("ovf_clr_state", 32'(state), 0);
        chk("ovf_clr_err", 32'(err_code), 0);
        chk("ovf_clr_pulse", 32'(calc_clear), 1);
        step();
        chk("ovf_clr_pulse_end", 32'(calc_clear), 0);

        // 255 is the largest operand; then let the result time out
        tok(4'd2);
        tok(4'd5);
        tok(4'd5);
        chk("max_state", 32'(state), 0);
        chk("max_err", 32'(err_code), 0);
        tok(4'd14);
        chk("max_operand", 32'(bus_if.calc_operand), 255);
        step();
        chk("to_wait", 32'(state), 2);
        for (int i = 0; i < 7; i++) step();
        chk("to_last_wait", 32'(state), 2);
        step();
        chk("to_state", 32'(state), 4);
        chk("to_err", 32'(err_code), 4);
        tok(4'd15);
        step();

        // Result in the last allowed cycle wins over timeout
        tok(4'd4);
        tok(4'd14);
        step();
        for (int i = 0; i < 7; i++) step();
        bus_if.result_valid = 1'b1;
        bus_if.result       = 8'd9;
        step();
        bus_if.result_valid = 1'b0;
        chk("late_res_state", 32'(state), 3);
        chk("late_res_answer", 32'(answer), 9);
        chk("late_res_err", 32'(err_code), 0);
        tok(4'd15);

        // Syntax: operator first, and '=' right after '+'
        tok(4'd10);
        chk("syn1_state", 32'(state), 4);
        chk("syn1_err", 32'(err_code), 2);
        tok(4'd15);
        tok(4'd1);
        tok(4'd10);
        step();
        tok(4'd14);
        chk("syn2_state", 32'(state), 4);
        chk("syn2_err", 32'(err_code), 2);
        tok(4'd15);

        // Calculator stalls 5 cycles; offered tokens must not be taken
        bus_if.calc_ready = 1'b0;
        tok(4'd4);
        tok(4'd2);
        tok(4'd11);
        bus_if.token_valid = 1'b1;
        bus_if.token       = 4'd9;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(bus_if.calc_valid), 1);
            chk("stall_operand", 32'(bus_if.calc_operand), 42);
            chk("stall_op", 32'(bus_if.calc_op), 11);
            chk("stall_tready", 32'(bus_if.token_ready), 0);
            step();
        end
        bus_if.token_valid = 1'b0;
        bus_if.calc_ready  = 1'b1;
        step();
        chk("stall_done_state", 32'(state), 0);
        // No digit was absorbed, so '=' is a syntax error
        tok(4'd14);
        chk("stall_no_digit", 32'(err_code), 2);
        tok(4'd15);

        // Calculator error
        tok(4'd3);
        tok(4'd14);
        step();
        bus_if.result_valid = 1'b1;
        bus_if.result_error = 1'b1;
        step();
        bus_if.result_valid = 1'b0;
        bus_if.result_error = 1'b0;
        chk("calc_err_state", 32'(state), 4);
        chk("calc_err_code", 32'(err_code), 3);
        tok(4'd15);

        // Reset mid-SEND drops calc_valid with no clear pulse
        bus_if.calc_ready = 1'b0;
        step();
        tok(4'd5);
        tok(4'd10);
        chk("rsend_valid_pre", 32'(bus_if.calc_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsend_valid", 32'(bus_if.calc_valid), 0);
        chk("rsend_state", 32'(state), 0);
        chk("rsend_clear", 32'(calc_clear), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
